// File: rtl/mont_pkg.sv
// Shared constants for the radix-2 Montgomery sequencing front end and kernel:
// default operand/word widths, FSM state encodings and the word-count helper.
package mont_pkg;

  localparam int DW_DEF = 6;
  localparam int W_DEF  = 3;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_ITER   = 3'd1;
  localparam state_t ST_REDUCE = 3'd2;
  localparam state_t ST_SELECT = 3'd3;
  localparam state_t ST_DONE   = 3'd4;

  function automatic int ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

endpackage

// File: rtl/mont_word_alu.sv
// One word slice of the Montgomery S update: {cout, sum} = s + xi*y + q*m + cin.
// Purely combinational; the carry can reach 2, hence two carry bits.
module mont_word_alu
  import mont_pkg::*;
#(
  parameter int WORD_W = W_DEF
) (
  input  logic [WORD_W-1:0] s_i,
  input  logic [WORD_W-1:0] y_i,
  input  logic [WORD_W-1:0] m_i,
  input  logic              xi_i,
  input  logic              q_i,
  input  logic [1:0]        cin_i,
  output logic [WORD_W-1:0] sum_o,
  output logic [1:0]        cout_o
);

  logic [WORD_W+1:0] acc;

  // Widen every addend to WORD_W+2 bits so the three-operand sum plus carry cannot overflow.
  always_comb begin
    acc = (WORD_W+2)'(s_i)
        + (xi_i ? (WORD_W+2)'(y_i) : '0)
        + (q_i  ? (WORD_W+2)'(m_i) : '0)
        + (WORD_W+2)'(cin_i);
  end

  assign sum_o  = acc[WORD_W-1:0];
  assign cout_o = acc[WORD_W+1:WORD_W];

endmodule

// File: rtl/mont_seq_driver.sv
// Radix-2 Montgomery sequencer: accepts X, Y, M, consumes one bit of X per
// iteration (LSB first), updates S one word per cycle and returns
// Z = X*Y*2^-DATA_W mod M. Build option MONT_FINAL_SUB_EN adds the REDUCE and
// SELECT phases that fold S from [0, 2M) into [0, M); without it the raw S is
// returned for chained operations.
module mont_seq_driver
  import mont_pkg::*;
#(
  parameter int DATA_W = DW_DEF,
  parameter int WORD_W = W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] X,
  input  logic [DATA_W-1:0] Y,
  input  logic [DATA_W-1:0] M,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W:0]   Z,
  output logic              busy
);

  localparam int E  = ceil_div(DATA_W + 1, WORD_W);
  localparam int EW = E * WORD_W;
  localparam int IW = $clog2(DATA_W + 1);
  localparam int JW = $clog2(E + 1);
  localparam logic [IW-1:0] I_LAST = IW'(DATA_W - 1);
  localparam logic [JW-1:0] J_LAST = JW'(E - 1);

  state_t            st_q, st_d;
  logic [IW-1:0]     i_q;
  logic [JW-1:0]     j_q;
  logic [DATA_W-1:0] xsh_q;
  logic [EW-1:0]     y_q, m_q, s_q;
  logic [WORD_W-1:0] tprev_q;
  logic              q_q;
  logic [1:0]        c_q;

  int                jx, jm1;
  logic              j_first, j_last, xi, q_cur;
  logic [1:0]        cin;
  logic [WORD_W-1:0] s_w, y_w, m_w, alu_sum;
  logic [1:0]        alu_cout;

`ifdef MONT_FINAL_SUB_EN
  logic [EW-1:0]     d_q;
  logic              b_q;
  logic [WORD_W:0]   diff;
`endif

  // Word selection and per-word control: q is formed at word 0 and held for the rest of the iteration.
  always_comb begin
    jx      = int'(j_q);
    jm1     = (jx == 0) ? 0 : jx - 1;
    j_first = (j_q == '0);
    j_last  = (j_q == J_LAST);
    xi      = xsh_q[0];
    s_w     = s_q[jx*WORD_W +: WORD_W];
    y_w     = y_q[jx*WORD_W +: WORD_W];
    m_w     = m_q[jx*WORD_W +: WORD_W];
    q_cur   = j_first ? (s_w[0] ^ (xi & y_w[0])) : q_q;
    cin     = j_first ? 2'b00 : c_q;
  end

  mont_word_alu #(.WORD_W(WORD_W)) u_alu (
    .s_i   (s_w),
    .y_i   (y_w),
    .m_i   (m_w),
    .xi_i  (xi),
    .q_i   (q_cur),
    .cin_i (cin),
    .sum_o (alu_sum),
    .cout_o(alu_cout)
  );

`ifdef MONT_FINAL_SUB_EN
  // Inline word subtractor for S - M; the top bit of the extended difference is the borrow out.
  always_comb begin
    diff = {1'b0, s_w} - {1'b0, m_w} - (WORD_W+1)'(j_first ? 1'b0 : b_q);
  end
`endif

  // Next-state logic of the operation sequencer.
  always_comb begin
    st_d = st_q;
    case (st_q)
      ST_IDLE: if (in_valid) st_d = ST_ITER;
      ST_ITER: if (j_last && (i_q == I_LAST)) begin
`ifdef MONT_FINAL_SUB_EN
        st_d = ST_REDUCE;
`else
        st_d = ST_DONE;
`endif
      end
`ifdef MONT_FINAL_SUB_EN
      ST_REDUCE: if (j_last) st_d = ST_SELECT;
      ST_SELECT: st_d = ST_DONE;
`endif
      ST_DONE: if (out_ready) st_d = ST_IDLE;
      default: st_d = ST_IDLE;
    endcase
  end

  // State register and iteration/word counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      st_q <= ST_IDLE;
      i_q  <= '0;
      j_q  <= '0;
    end else begin
      st_q <= st_d;
      case (st_q)
        ST_IDLE: if (in_valid) begin
          i_q <= '0;
          j_q <= '0;
        end
        ST_ITER: if (j_last) begin
          j_q <= '0;
          i_q <= i_q + IW'(1);
        end else begin
          j_q <= j_q + JW'(1);
        end
`ifdef MONT_FINAL_SUB_EN
        ST_REDUCE: j_q <= j_last ? '0 : j_q + JW'(1);
`endif
        default: ;
      endcase
    end
  end

  // Operand latches and word-to-word carry/quotient state; no reset needed as each is loaded before use.
  always_ff @(posedge clk) begin
    case (st_q)
      ST_IDLE: if (in_valid) begin
        xsh_q <= X;
        y_q   <= {{(EW-DATA_W){1'b0}}, Y};
        m_q   <= {{(EW-DATA_W){1'b0}}, M};
      end
      ST_ITER: begin
        tprev_q <= alu_sum;
        c_q     <= alu_cout;
        if (j_first) q_q <= q_cur;
        if (j_last) xsh_q <= xsh_q >> 1;
      end
`ifdef MONT_FINAL_SUB_EN
      ST_REDUCE: begin
        d_q[jx*WORD_W +: WORD_W] <= diff[WORD_W-1:0];
        b_q                      <= diff[WORD_W];
      end
`endif
      default: ;
    endcase
  end

  // S accumulator: each word result is stored shifted right by one, pulling the low bit of the next word.
  always_ff @(posedge clk) begin
    if (rst) begin
      s_q <= '0;
    end else begin
      case (st_q)
        ST_IDLE: if (in_valid) s_q <= '0;
        ST_ITER: begin
          if (!j_first) s_q[jm1*WORD_W +: WORD_W] <= {alu_sum[0], tprev_q[WORD_W-1:1]};
          if (j_last)   s_q[jx*WORD_W +: WORD_W]  <= {alu_cout[0], alu_sum[WORD_W-1:1]};
        end
`ifdef MONT_FINAL_SUB_EN
        ST_SELECT: if (!b_q) s_q <= d_q;
`endif
        default: ;
      endcase
    end
  end

  // S < 2M keeps the top carry at most 1; a larger carry means an operand violated Y < M or odd M.
  always_ff @(posedge clk) begin
    if (!rst && (st_q == ST_ITER) && j_last) assert (alu_cout <= 2'd1);
  end

  assign in_ready  = (st_q == ST_IDLE);
  assign busy      = (st_q != ST_IDLE);
  assign out_valid = (st_q == ST_DONE);
  assign Z         = out_valid ? s_q[DATA_W:0] : '0;

endmodule

// File: tb/tb_mont_seq_driver.sv
// Bench for mont_seq_driver (dw=6, w=3). Honours MONT_FINAL_SUB_EN the same
// way the design does: exact reduced result with the macro, raw S otherwise.
module tb_mont_seq_driver;

  localparam int DW = 6;
`ifdef MONT_FINAL_SUB_EN
  localparam int LAT = 23;
`else
  localparam int LAT = 19;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] X, Y, M;
  logic          out_valid;
  logic          out_ready;
  logic [DW:0]   Z;
  logic          busy;

  int vectors     = 0;
  int miscompares = 0;
  int lat_cnt;

  always #5 clk = ~clk;

  mont_seq_driver dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .X        (X),
    .Y        (Y),
    .M        (M),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .Z        (Z),
    .busy     (busy)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Bit-serial definition of radix-2 Montgomery: S = (S + xi*Y + q*M) / 2.
  function automatic int mont_raw(input int x, input int y, input int m);
    int s = 0;
    for (int k = 0; k < DW; k++) begin
      int t;
      t = s + ((x >> k) & 1) * y;
      t = t + (t & 1) * m;
      s = t / 2;
    end
    return s;
  endfunction

  // The unique z in [0, m) with z * 2^DW == x*y (mod m).
  function automatic int mont_true(input int x, input int y, input int m);
    int target = (x * y) % m;
    for (int z = 0; z < m; z++)
      if (((z << DW) % m) == target) return z;
    return -1;
  endfunction

  // Present operands, pass the accept edge, leave us at the following negedge.
  task automatic start_op(input int x, input int y, input int m);
    @(negedge clk);
    chk("in_ready_before_accept", in_ready, 1);
    X = DW'(x); Y = DW'(y); M = DW'(m); in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    X = DW'($urandom); Y = DW'($urandom); M = DW'($urandom);
    chk("in_ready_after_accept", in_ready, 0);
    chk("busy_after_accept", busy, 1);
  endtask

  // Count edges from accept until out_valid is seen; spurious in_valid pulses must be ignored.
  task automatic wait_out();
    lat_cnt = 1;
    while (!out_valid && lat_cnt < 200) begin
      in_valid = (lat_cnt < 5);
      @(negedge clk);
      lat_cnt++;
    end
    in_valid = 1'b0;
    if (!out_valid) chk("out_valid_timeout", 0, 1);
  endtask

  task automatic do_op(input int x, input int y, input int m, input int hold, input int expc);
    int zt, raw, zobs;
    start_op(x, y, m);
    wait_out();
    if (!out_valid) return;
    chk("latency", lat_cnt, LAT);
    zt   = mont_true(x, y, m);
    raw  = mont_raw(x, y, m);
    zobs = int'(Z);
`ifdef MONT_FINAL_SUB_EN
    chk("z_exact", zobs, zt);
    chk("z_model", zobs, (raw >= m) ? raw - m : raw);
`else
    chk("z_raw", zobs, raw);
    chk("z_congruent", zobs % m, zt);
    chk("z_below_2m", int'(zobs < 2 * m), 1);
`endif
    if (expc >= 0) chk("z_directed", zobs % m, expc);
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      chk("hold_out_valid", out_valid, 1);
      chk("hold_z", int'(Z), zobs);
      chk("hold_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("in_ready_after_handshake", in_ready, 1);
    chk("out_valid_after_handshake", out_valid, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int seen;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    X = '0; Y = '0; M = '0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_z", int'(Z), 0);
    rst = 1'b0;

    do_op(1, 1, 61, 0, 41);
    do_op(5, 9, 61, 0, 15);
    do_op(60, 60, 61, 0, 41);
    do_op(0, 37, 61, 10, 0);

    // Abort an operation with reset ten cycles after accept.
    start_op(1, 1, 61);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_in_ready", in_ready, 1);
    chk("abort_out_valid", out_valid, 0);
    chk("abort_busy", busy, 0);
    rst = 1'b0;
    seen = 0;
    repeat (25) begin
      @(negedge clk);
      if (out_valid) seen = 1;
    end
    chk("abort_no_output", seen, 0);
    do_op(1, 1, 61, 0, 41);

    // Sweep every odd modulus with random operands and random consumer stalls.
    for (int m = 1; m < 64; m += 2) begin
      repeat (2) begin
        do_op(int'($urandom_range(0, m - 1)), int'($urandom_range(0, m - 1)), m,
              int'($urandom_range(0, 3)), -1);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mont_seq_driver.md
# mont_seq_driver

Sequencing front end for radix-2 Montgomery multiplication. It is the issuing side of the bit/word stream that the per-iteration kernel consumes. It accepts operands X, Y, M through a valid/ready handshake and serialises X one bit per iteration (MSB-last). It runs the word-serial S update over e words per iteration, applies the final conditional subtraction, and returns Z = X·Y·2^-dw mod M through a second valid/ready handshake.

## Interface
- dw, 6: operand width in bits.
- w, 3: word width in bits.
- e (localparam): ceil((dw+1)/w), the number of words in S, Y and M. Default 3.
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operands X/Y/M present.
- in_ready  out  1  driver idle and able to accept.
- X  in  dw  multiplier, serialised LSB first.
- Y  in  dw  multiplicand; requires Y < M.
- M  in  dw  modulus; must be odd.
- out_valid  out  1  Z valid.
- out_ready  in  1  consumer accepts Z.
- Z  out  dw+1  result. MSB is always 0 when the final subtraction is compiled in.
- busy  out  1  high from the accept edge until the output handshake completes.

## Operation
- Registers:
  - X_sh[dw-1:0]: shifts right once per iteration; xi = X_sh[0].
  - Y and M: padded to e·w bits, split into words Yj and Mj.
  - S words: S[0..e-1], w bits each.
  - q (1 bit) and carry C (2 bits).
  - Counters: i (0..dw-1) and j (0..e-1).
- States:
  - IDLE: in_ready=1. On in_valid, latch X, Y, M; clear S and i; go to ITER with j=0.
  - ITER, word j step: {C', T} = S[j] + xi·Y[j] + q·M[j] + C, with q = (S[0]+xi·Y[0])[0] computed combinationally at j=0 and registered for j≥1. C=0 at j=0.
    - For j≥1: write S[j-1] = {T[0], T_prev[w-1:1]}, where T_prev is the registered word j-1 result.
    - At j=e-1: write S[e-1] = {C'[0], T[w-1:1]}.
    - At j=e-1, also clear j, shift X_sh and increment i. After i=dw-1 go to REDUCE (or to DONE without the macro).
  - REDUCE: word-serial D[j] = S[j] − M[j] − borrow over e cycles. D is stored in a shadow register.
  - SELECT: 1 cycle. If the final borrow is 0 (S ≥ M), S ← D; otherwise S is kept.
  - DONE: out_valid=1, Z = S[dw:0]. Hold until out_ready, then return to IDLE.
- Invariant: S < 2M after every iteration. C never exceeds 1 at j=e-1; a value above 1 is an assertion failure.
- in_valid is ignored outside IDLE. Inputs are sampled only on the accept edge.

## Timing
- Reset values:
  - in_ready=1, out_valid=0, busy=0, Z=0, all S words 0, state IDLE.
  - Reset mid-operation aborts within 1 cycle. No output is produced.
- Accept edge: the edge with in_valid & in_ready. in_ready drops the next cycle.
- Iteration length: e cycles. ITER lasts dw·e cycles (18 at default).
- Latency from the accept edge to out_valid rising:
  - With the macro: dw·e + e + 2, i.e. 23 at default.
  - Without the macro: dw·e + 1, i.e. 19 at default.
- Z is stable while out_valid=1 and out_ready=0.
- in_ready rises the cycle after the output handshake. Back-to-back throughput is one result per latency + 1 cycles.
- Boundary cases:
  - X=0 gives S=0 every iteration, so Z=0.
  - dw a multiple of w is still valid, since e always covers dw+1 bits.

## Configuration
- MONT_FINAL_SUB_EN defined: REDUCE and SELECT are present and Z ∈ [0, M).
- MONT_FINAL_SUB_EN undefined: ITER goes straight to DONE and Z is the raw S ∈ [0, 2M), which is congruent to the true result mod M. This mode is for chained Montgomery operations.

## Structure
- Package mont_pkg holds:
  - the state enum;
  - function ceil_div(a, b) for e;
  - default dw and w constants, shared with the kernel.
- Sub-module mont_word_alu is combinational: {cout[1:0], sum[w-1:0]} = s + xi·y + q·m + cin. It is instanced once in ITER.
- REDUCE uses a separate inline subtractor.

## Test plan
All cases use dw=6 and w=3, with MONT_FINAL_SUB_EN defined unless stated.
- M=61, X=1, Y=1: Z=41 (64^-1 mod 61), out_valid at accept+23.
- M=61, X=5, Y=9 (R² mod M): Z=15 (5·64 mod 61).
- M=61, X=60, Y=60: Z=41. Check C≤1 every iteration.
- X=0, Y=37, M=61: Z=0. Then hold out_ready=0 for 10 cycles: Z and out_valid stay stable, and in_ready stays 0.
- Assert rst at cycle 10 after accept: in_ready=1 and out_valid=0 next cycle. A new operation (M=61, X=1, Y=1) then gives Z=41.
- Macro undefined, same vectors: out_valid at accept+19, Z<122, Z mod 61 equals the expected values. Random sweep over all odd M<64 with X, Y < M is checked against a reference model.
